// File: rtl/weight_ram_pkg.sv
// Shared constants and types for the WeightRAM access scheduler.
// Geometry matches the WeightRAM instance: 128 rows of 10 lanes x 10 bits.
package weight_ram_pkg;

  localparam int LANES = 10;
  localparam int DW    = 10;
  localparam int AW    = 7;
  localparam int LW    = 4;
  localparam int DEPTH = 1 << AW;
  localparam int RW    = LANES * DW;

  localparam logic [LW-1:0] LANE_LIMIT = LW'(LANES);

  typedef logic [RW-1:0] row_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_ISSUE,
    ST_RD_CAP,
    ST_DL_RD,
    ST_DL_WAIT,
    ST_DL_WR,
    ST_CLR,
    ST_RAND
  } state_t;

  // Every scheduler output, held in one register bank.
  typedef struct packed {
    logic          rd_ack;
    logic          rd_valid;
    row_t          rd_data;
    logic          dl_ack;
    logic          dl_err;
    logic          busy;
    logic [AW-1:0] ram_addr;
    row_t          ram_d;
    logic          ram_we;
    logic          ram_in;
  } out_t;

  function automatic logic lane_ok(input logic [LW-1:0] lane);
    return lane < LANE_LIMIT;
  endfunction

endpackage

// File: rtl/weight_lane_merge.sv
// Replaces one lane of a WeightRAM row with a new weight, leaving the
// other lanes untouched; out-of-range lanes pass the row through.
module weight_lane_merge
  import weight_ram_pkg::*;
(
  input  logic [RW-1:0] row,
  input  logic [LW-1:0] lane,
  input  logic [DW-1:0] data,
  output logic [RW-1:0] merged
);

  always_comb begin
    merged = row;
    for (int i = 0; i < LANES; i++) begin
      if (lane == LW'(i)) merged[i*DW +: DW] = data;
    end
  end

endmodule

// File: rtl/weight_ram_scheduler.sv
// Arbitrates WeightRAM between inference row reads and single-lane weight
// downloads (read-modify-write), and sequences full clear and randomize.
module weight_ram_scheduler
  import weight_ram_pkg::*;
#(
  parameter int STARVE_MAX = 8
) (
  input  logic                CLOCK_50,
  input  logic                rst,
  input  logic                rd_req,
  input  logic [AW-1:0]       rd_addr,
  output logic                rd_ack,
  output logic                rd_valid,
  output logic [RW-1:0]       rd_data,
  input  logic                dl_req,
  input  logic [AW-1:0]       dl_addr,
  input  logic [LW-1:0]       dl_lane,
  input  logic [DW-1:0]       dl_data,
  output logic                dl_ack,
  output logic                dl_err,
  input  logic                clr_req,
  input  logic                rand_req,
  output logic                busy,
  output logic [AW-1:0]       ram_addr,
  output logic [RW-1:0]       ram_d,
  output logic                ram_we,
  output logic                ram_in,
  input  logic [RW-1:0]       ram_q
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIMIT = SW'(STARVE_MAX);

  state_t        state, state_nxt;
  out_t          o_q, o_d;
  logic [SW-1:0] starve_cnt, starve_nxt;
  logic [AW-1:0] clr_cnt, clr_nxt;
  logic [LW-1:0] lane_q;
  logic [DW-1:0] data_q;
  row_t          merged_row;

  logic in_idle, rd_ok, dl_ok, dl_force;
  logic clr_go, rand_go, dl_go, rd_go, dl_bad;

  // A request whose ack is on the outputs this cycle is the one just served.
  assign in_idle  = (state == ST_IDLE);
  assign rd_ok    = rd_req && !o_q.rd_ack;
  assign dl_ok    = dl_req && !o_q.dl_ack;
  assign dl_force = dl_ok && (starve_cnt == STARVE_LIMIT);

  assign clr_go  = in_idle && clr_req;
  assign rand_go = in_idle && !clr_req && rand_req;
  assign dl_go   = in_idle && !clr_req && !rand_req && (dl_force || (dl_ok && !rd_ok));
  assign rd_go   = in_idle && !clr_req && !rand_req && !dl_force && rd_ok;
  assign dl_bad  = !lane_ok(dl_lane);

  weight_lane_merge u_merge (
    .row    (ram_q),
    .lane   (lane_q),
    .data   (data_q),
    .merged (merged_row)
  );

  // NOTE: sequential state uses <= so every register samples pre-edge values;
  // reset here is synchronous and clears every output, including the row buses.
  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      state      <= ST_IDLE;
      o_q        <= '0;
      starve_cnt <= '0;
      clr_cnt    <= '0;
      lane_q     <= '0;
      data_q     <= '0;
    end else begin
      state      <= state_nxt;
      o_q        <= o_d;
      starve_cnt <= starve_nxt;
      clr_cnt    <= clr_nxt;
      if (dl_go) begin
        lane_q <= dl_lane;
        data_q <= dl_data;
      end
    end
  end

  // NOTE: each always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_nxt  = state;
    clr_nxt    = clr_cnt;
    starve_nxt = starve_cnt;

    unique case (state)
      ST_IDLE: begin
        if (clr_go)       state_nxt = ST_CLR;
        else if (rand_go) state_nxt = ST_RAND;
        else if (dl_go)   state_nxt = dl_bad ? ST_IDLE : ST_DL_RD;
        else if (rd_go)   state_nxt = ST_RD_ISSUE;
      end
      ST_RD_ISSUE: state_nxt = ST_RD_CAP;
      ST_RD_CAP:   state_nxt = ST_IDLE;
      ST_DL_RD:    state_nxt = ST_DL_WAIT;
      ST_DL_WAIT:  state_nxt = ST_DL_WR;
      ST_DL_WR:    state_nxt = ST_IDLE;
      ST_CLR:      if (clr_cnt == '1) state_nxt = ST_IDLE;
      ST_RAND:     state_nxt = ST_IDLE;
      default:     state_nxt = ST_IDLE;
    endcase

    if (clr_go) clr_nxt = '0;
    else if (state == ST_CLR && clr_cnt != '1) clr_nxt = clr_cnt + AW'(1);

    // Reads may only starve a waiting download for STARVE_MAX grants.
    if (!dl_req || dl_go) starve_nxt = '0;
    else if (rd_go && starve_cnt != STARVE_LIMIT) starve_nxt = starve_cnt + SW'(1);
  end

  always_comb begin
    o_d          = o_q;
    o_d.rd_ack   = 1'b0;
    o_d.rd_valid = 1'b0;
    o_d.dl_ack   = 1'b0;
    o_d.dl_err   = 1'b0;
    o_d.ram_we   = 1'b0;
    o_d.ram_in   = 1'b0;
    o_d.busy     = (state_nxt != ST_IDLE);

    unique case (state)
      ST_IDLE: begin
        if (clr_go) begin
          o_d.ram_addr = '0;
          o_d.ram_d    = '0;
          o_d.ram_we   = 1'b1;
        end else if (rand_go) begin
          o_d.ram_in = 1'b1;
        end else if (dl_go) begin
          o_d.ram_addr = dl_addr;
          if (dl_bad) begin
            o_d.dl_ack = 1'b1;
            o_d.dl_err = 1'b1;
          end
        end else if (rd_go) begin
          o_d.ram_addr = rd_addr;
          o_d.rd_ack   = 1'b1;
        end
      end
      ST_RD_CAP: begin
        o_d.rd_data  = ram_q;
        o_d.rd_valid = 1'b1;
      end
      // The addressed row is on ram_q now; write it back with one lane replaced.
      ST_DL_WAIT: begin
        o_d.ram_d  = merged_row;
        o_d.ram_we = 1'b1;
        o_d.dl_ack = 1'b1;
      end
      ST_CLR: begin
        if (clr_cnt != '1) begin
          o_d.ram_addr = clr_cnt + AW'(1);
          o_d.ram_d    = '0;
          o_d.ram_we   = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign rd_ack   = o_q.rd_ack;
  assign rd_valid = o_q.rd_valid;
  assign rd_data  = o_q.rd_data;
  assign dl_ack   = o_q.dl_ack;
  assign dl_err   = o_q.dl_err;
  assign busy     = o_q.busy;
  assign ram_addr = o_q.ram_addr;
  assign ram_d    = o_q.ram_d;
  assign ram_we   = o_q.ram_we;
  assign ram_in   = o_q.ram_in;

endmodule
